// File: rtl/pll_sup_pkg.sv
// Shared types and sizing helpers for the PLL lock supervisor.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    RESET,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAULT
  } state_e;

  localparam int LOCK_LOSS_W = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Width of the shared down-counter, sized for the longest phase.
  function automatic int cnt_width(input int rst_pulse, input int timeout, input int stable);
    return $clog2(max3(rst_pulse, timeout, stable) + 1);
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// Control/status bundle between the PLL lock supervisor and its user.
interface pll_lock_supervisor_if #(
  parameter int MAX_RETRIES = 3
);

  logic                                  pll_locked;
  logic                                  soft_reset_req;
  logic                                  pll_rst;
  logic                                  sys_rst_n;
  logic                                  ready;
  logic                                  fault;
  logic [$clog2(MAX_RETRIES+1)-1:0]      retry_count;
  logic [pll_sup_pkg::LOCK_LOSS_W-1:0]   lock_loss_count;

  modport master (
    output pll_locked, soft_reset_req,
    input  pll_rst, sys_rst_n, ready, fault, retry_count, lock_loss_count
  );

  modport slave (
    input  pll_locked, soft_reset_req,
    output pll_rst, sys_rst_n, ready, fault, retry_count, lock_loss_count
  );

endinterface

// File: rtl/pll_sup_sync.sv
// Multi-flop synchronizer bringing the asynchronous PLL lock flag onto refclk.
module pll_sup_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic refclk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic [SYNC_STAGES-1:0] r_sync;

  // NOTE: the chain is cleared by reset so a lock seen before rst_n cannot leak through.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer: pulses pll_rst, qualifies lock, releases sys_rst_n, retries then faults.
// Define PLL_SUP_LOCK_LOSS_COUNT_EN to enable the lock-loss event counter.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_PULSE_CYC    = 16,
  parameter int LOCK_TIMEOUT_CYC = 100000,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int MAX_RETRIES      = 3,
  parameter int SYNC_STAGES      = 2
) (
  input logic                  refclk,
  input logic                  rst_n,
  pll_lock_supervisor_if.slave bus
);

  localparam int CNT_W = cnt_width(RST_PULSE_CYC, LOCK_TIMEOUT_CYC, LOCK_STABLE_CYC);
  localparam int RW    = $clog2(MAX_RETRIES + 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [RW-1:0]    r_retry;
  logic [RW-1:0]    w_retry_nxt;
  logic [RW-1:0]    w_retry_inc;
  logic             w_lock_s;
  logic             r_pll_rst;
  logic             r_sys_rst_n;
  logic             r_ready;
  logic             r_fault;

  pll_sup_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .refclk  (refclk),
    .rst_n   (rst_n),
    .i_async (bus.pll_locked),
    .o_sync  (w_lock_s)
  );

  // Each phase lasts load+1 cycles: the counter expires on the cycle it reads zero.
  function automatic logic [CNT_W-1:0] cnt_load(input state_e s);
    case (s)
      RESET:     cnt_load = CNT_W'(RST_PULSE_CYC - 1);
      WAIT_LOCK: cnt_load = CNT_W'(LOCK_TIMEOUT_CYC - 1);
      STABLE:    cnt_load = CNT_W'(LOCK_STABLE_CYC - 1);
      default:   cnt_load = '0;
    endcase
  endfunction

  assign w_retry_inc = (r_retry == RETRY_MAX) ? r_retry : r_retry + RW'(1);

  // NOTE: every variable gets a default first, so no path can leave one unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_retry_nxt = r_retry;

    if (bus.soft_reset_req) begin
      w_state_nxt = RESET;
      w_retry_nxt = '0;
    end else begin
      case (r_state)
        RESET: begin
          if (r_cnt == '0) w_state_nxt = WAIT_LOCK;
          else             w_cnt_nxt   = r_cnt - CNT_W'(1);
        end
        WAIT_LOCK: begin
          if (w_lock_s) begin
            w_state_nxt = STABLE;
          end else if (r_cnt == '0) begin
            w_retry_nxt = w_retry_inc;
            w_state_nxt = (w_retry_inc == RETRY_MAX) ? FAULT : RESET;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
        STABLE: begin
          if (!w_lock_s)          w_state_nxt = WAIT_LOCK;
          else if (r_cnt == '0)   w_state_nxt = RUN;
          else                    w_cnt_nxt   = r_cnt - CNT_W'(1);
        end
        RUN: begin
          if (!w_lock_s) w_state_nxt = RESET;
        end
        FAULT: begin
          w_state_nxt = FAULT;
        end
        default: begin
          w_state_nxt = RESET;
        end
      endcase
    end

    // A soft request while already in RESET still restarts the pulse.
    if ((w_state_nxt != r_state) || bus.soft_reset_req) w_cnt_nxt = cnt_load(w_state_nxt);
    if (w_state_nxt == RUN) w_retry_nxt = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      r_state     <= RESET;
      r_cnt       <= cnt_load(RESET);
      r_retry     <= '0;
      r_pll_rst   <= 1'b1;
      r_sys_rst_n <= 1'b0;
      r_ready     <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_retry     <= w_retry_nxt;
      r_pll_rst   <= (w_state_nxt == RESET) || (w_state_nxt == FAULT);
      r_sys_rst_n <= (w_state_nxt == RUN);
      r_ready     <= (w_state_nxt == RUN);
      r_fault     <= (w_state_nxt == FAULT);
    end
  end

  assign bus.pll_rst     = r_pll_rst;
  assign bus.sys_rst_n   = r_sys_rst_n;
  assign bus.ready       = r_ready;
  assign bus.fault       = r_fault;
  assign bus.retry_count = r_retry;

`ifdef PLL_SUP_LOCK_LOSS_COUNT_EN
  logic [LOCK_LOSS_W-1:0] r_lock_loss;
  logic                   w_lock_lost;

  // A soft request in RUN is a deliberate restart, not a lock loss.
  assign w_lock_lost = (r_state == RUN) && !w_lock_s && !bus.soft_reset_req;

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      r_lock_loss <= '0;
    end else if (w_lock_lost && (r_lock_loss != '1)) begin
      r_lock_loss <= r_lock_loss + LOCK_LOSS_W'(1);
    end
  end

  assign bus.lock_loss_count = r_lock_loss;
`else
  assign bus.lock_loss_count = '0;
`endif

endmodule
